// File: rtl/params_pkg.sv
// params_pkg -- shared configuration for the CDB arbiter slice.
//   NUM_FU/TAG_WIDTH/DATA_WIDTH/CYCLE_WIDTH : default bus geometry
//   SRC_WIDTH                               : width of an FU index
//   cdb_bcast_t                             : one registered CDB broadcast
// The broadcast struct is sized from these constants, so a build that
// overrides the module parameters must change them here as well.
package params_pkg;

  localparam int NUM_FU      = 4;
  localparam int TAG_WIDTH   = 3;
  localparam int DATA_WIDTH  = 32;
  localparam int CYCLE_WIDTH = 8;
  localparam int SRC_WIDTH   = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  typedef struct packed {
    logic                  valid;
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] value;
    logic [SRC_WIDTH-1:0]  src;
  } cdb_bcast_t;

endpackage

// File: rtl/cdb_pick.sv
// cdb_pick -- combinational winner selection for the CDB arbiter.
//   req_valid : per-FU request bits
//   req_tag   : per-FU ROB tag (age mode only)
//   rob_head  : oldest ROB tag (age mode only)
//   rr_ptr    : highest-priority FU (round-robin mode only)
//   gnt_any   : some requester won
//   gnt_idx   : index of the winner (0 when gnt_any is low)
// Macro CDB_AGE_PRIO_EN selects oldest-first by ROB age instead of
// round-robin.
module cdb_pick #(
  parameter int NUM_FU    = 4,
  parameter int TAG_WIDTH = 3,
  parameter int SRC_WIDTH = 2
) (
  input  logic [NUM_FU-1:0]                req_valid,
  input  logic [NUM_FU-1:0][TAG_WIDTH-1:0] req_tag,
  input  logic [TAG_WIDTH-1:0]             rob_head,
  input  logic [SRC_WIDTH-1:0]             rr_ptr,
  output logic                             gnt_any,
  output logic [SRC_WIDTH-1:0]             gnt_idx
);

`ifdef CDB_AGE_PRIO_EN
  logic unused_rr;
  assign unused_rr = ^rr_ptr;

  // Age is distance from the ROB head modulo the ROB depth; the strict
  // compare keeps the lowest index on ties.
  always_comb begin
    logic [TAG_WIDTH-1:0] best;
    logic [TAG_WIDTH-1:0] age;
    gnt_any = 1'b0;
    gnt_idx = '0;
    best    = '1;
    age     = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      age = req_tag[i] - rob_head;
      if (req_valid[i] && (!gnt_any || age < best)) begin
        gnt_any = 1'b1;
        gnt_idx = SRC_WIDTH'(i);
        best    = age;
      end
    end
  end
`else
  logic unused_age;
  assign unused_age = ^{rob_head, req_tag};

  // Walk the search order backwards so the last hit, i.e. the one
  // closest to rr_ptr, is the one that sticks.
  always_comb begin
    int unsigned idx;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = NUM_FU - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_FU;
      if (req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = SRC_WIDTH'(idx);
      end
    end
  end
`endif

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter -- grants one functional unit per cycle onto the common
// data bus and registers the broadcast (latency 1).
//   clk, reset        : clock, synchronous active-high reset
//   req_valid/tag/value : per-FU completed results
//   req_ready         : combinational one-hot grant
//   rob_head          : oldest ROB tag (used only in age mode)
//   flush             : squash, no grant this cycle
//   cdb_valid/tag/value/src : registered broadcast
//   conflict_cycles   : saturating count of cycles with >=2 requesters
// Macro CDB_AGE_PRIO_EN: oldest-ROB-entry-first instead of round-robin.
module cdb_arbiter
  import params_pkg::cdb_bcast_t;
#(
  parameter int NUM_FU      = params_pkg::NUM_FU,
  parameter int TAG_WIDTH   = params_pkg::TAG_WIDTH,
  parameter int DATA_WIDTH  = params_pkg::DATA_WIDTH,
  parameter int CYCLE_WIDTH = params_pkg::CYCLE_WIDTH,
  localparam int SRC_WIDTH  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_FU-1:0]                 req_valid,
  input  logic [NUM_FU-1:0][TAG_WIDTH-1:0]  req_tag,
  input  logic [NUM_FU-1:0][DATA_WIDTH-1:0] req_value,
  output logic [NUM_FU-1:0]                 req_ready,
  input  logic [TAG_WIDTH-1:0]              rob_head,
  input  logic                              flush,
  output logic                              cdb_valid,
  output logic [TAG_WIDTH-1:0]              cdb_tag,
  output logic [DATA_WIDTH-1:0]             cdb_value,
  output logic [SRC_WIDTH-1:0]              cdb_src,
  output logic [CYCLE_WIDTH-1:0]            conflict_cycles
);

  logic                   gnt_any;
  logic [SRC_WIDTH-1:0]   gnt_idx;
  logic                   grant;
  logic [SRC_WIDTH-1:0]   rr_ptr;
  cdb_bcast_t             bcast_q, bcast_d;
  logic [CYCLE_WIDTH-1:0] conflict_q, conflict_d;

`ifdef CDB_AGE_PRIO_EN
  assign rr_ptr = '0;
`else
  logic [SRC_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  assign rr_ptr = rr_ptr_q;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant)
      rr_ptr_d = (gnt_idx == SRC_WIDTH'(NUM_FU - 1)) ? '0 : gnt_idx + SRC_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end
`endif

  cdb_pick #(
    .NUM_FU    (NUM_FU),
    .TAG_WIDTH (TAG_WIDTH),
    .SRC_WIDTH (SRC_WIDTH)
  ) u_pick (
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .rob_head  (rob_head),
    .rr_ptr    (rr_ptr),
    .gnt_any   (gnt_any),
    .gnt_idx   (gnt_idx)
  );

  // Reset and flush both veto the grant in the same cycle.
  assign grant = gnt_any & ~flush & ~reset;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[gnt_idx] = 1'b1;
  end

  // Payload fields hold across idle cycles; only valid drops.
  always_comb begin
    bcast_d       = bcast_q;
    bcast_d.valid = grant;
    if (grant) begin
      bcast_d.tag   = req_tag[gnt_idx];
      bcast_d.value = req_value[gnt_idx];
      bcast_d.src   = gnt_idx;
    end
  end

  // Contention is counted on raw requests, so flushed cycles count too.
  always_comb begin
    conflict_d = conflict_q;
    if ($countones(req_valid) >= 2 && conflict_q != '1)
      conflict_d = conflict_q + CYCLE_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bcast_q    <= '0;
      conflict_q <= '0;
    end else begin
      bcast_q    <= bcast_d;
      conflict_q <= conflict_d;
    end
  end

  assign cdb_valid       = bcast_q.valid;
  assign cdb_tag         = bcast_q.tag;
  assign cdb_value       = bcast_q.value;
  assign cdb_src         = bcast_q.src;
  assign conflict_cycles = conflict_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

  localparam int N = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0][2:0] req_tag = '0;
  logic [N-1:0][31:0] req_value = '0;
  logic [N-1:0]      req_ready;
  logic [2:0]        rob_head = '0;
  logic              flush = 1'b0;
  logic              cdb_valid;
  logic [2:0]        cdb_tag;
  logic [31:0]       cdb_value;
  logic [1:0]        cdb_src;
  logic [7:0]        conflict_cycles;

  always #5 clk = ~clk;

  cdb_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_tag(req_tag),
    .req_value(req_value), .req_ready(req_ready), .rob_head(rob_head),
    .flush(flush), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_value(cdb_value), .cdb_src(cdb_src), .conflict_cycles(conflict_cycles)
  );

  int checks = 0;
  int errors = 0;

  // requester-side payloads
  logic [2:0]  tg[N];
  logic [31:0] vl[N];
  logic [N-1:0] last_ready;

  // reference model state
  int          m_ptr = 0;
  logic        m_cv = 0;
  logic [2:0]  m_tag = 0;
  logic [31:0] m_val = 0;
  int          m_src = 0;
  int          m_conf = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Winner per the arbitration rule, -1 if nobody requests.
  function automatic int mdl_pick(logic [N-1:0] v);
`ifdef CDB_AGE_PRIO_EN
    int best = -1;
    int bage = 1000;
    for (int i = 0; i < N; i++)
      if (v[i]) begin
        int a = (int'(tg[i]) - int'(rob_head) + 8) % 8;
        if (a < bage) begin bage = a; best = i; end
      end
    return best;
`else
    for (int k = 0; k < N; k++)
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
`endif
  endfunction

  task automatic step(input logic r, input logic f, input logic [N-1:0] v,
                      input string nm, input bit use_exp,
                      input logic [N-1:0] er, input logic ecv, input logic [1:0] esrc);
    int g;
    logic [N-1:0] mr;
    reset = r; flush = f; req_valid = v;
    for (int i = 0; i < N; i++) begin req_tag[i] = tg[i]; req_value[i] = vl[i]; end
    #1;
    g  = (r || f) ? -1 : mdl_pick(v);
    mr = '0;
    if (g >= 0) mr[g] = 1'b1;
    chk({nm, "_ready"}, 64'(req_ready), 64'(mr));
    if (use_exp) chk({nm, "_ready_tbl"}, 64'(req_ready), 64'(er));
    last_ready = req_ready;
    @(posedge clk);
    if (r) begin
      m_cv = 0; m_tag = 0; m_val = 0; m_src = 0; m_conf = 0; m_ptr = 0;
    end else begin
      m_cv = (g >= 0);
      if (g >= 0) begin m_tag = tg[g]; m_val = vl[g]; m_src = g; m_ptr = (g + 1) % N; end
      if ($countones(v) >= 2 && m_conf < 255) m_conf++;
    end
    #1;
    chk({nm, "_cdb_valid"}, 64'(cdb_valid), 64'(m_cv));
    chk({nm, "_cdb_tag"}, 64'(cdb_tag), 64'(m_tag));
    chk({nm, "_cdb_value"}, 64'(cdb_value), 64'(m_val));
    chk({nm, "_cdb_src"}, 64'(cdb_src), 64'(m_src));
    chk({nm, "_conflict"}, 64'(conflict_cycles), 64'(m_conf));
    if (use_exp) begin
      chk({nm, "_cv_tbl"}, 64'(cdb_valid), 64'(ecv));
      chk({nm, "_src_tbl"}, 64'(cdb_src), 64'(esrc));
    end
  endtask

  typedef struct {
    string        nm;
    logic         rst;
    logic         fl;
    logic [N-1:0] v;
    logic [N-1:0] er;
    logic         ecv;
    logic [1:0]   esrc;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(string nm, logic rst, logic fl, logic [N-1:0] v,
                              logic [N-1:0] er, logic ecv, logic [1:0] esrc);
    vec_t e;
    e.nm = nm; e.rst = rst; e.fl = fl; e.v = v; e.er = er; e.ecv = ecv; e.esrc = esrc;
    tbl.push_back(e);
  endfunction

  initial begin
    tg[0] = 3'd1; vl[0] = 32'h1111_1111;
    tg[1] = 3'd7; vl[1] = 32'h2222_2222;
    tg[2] = 3'd5; vl[2] = 32'hDEAD_BEEF;
    tg[3] = 3'd6; vl[3] = 32'h4444_4444;
    rob_head = 3'd6;
    #2;

    // reset wins over pending requests
    add("rst", 1, 0, 4'b1111, 4'b0000, 0, 2'd0);
`ifdef CDB_AGE_PRIO_EN
    add("age_fu3", 0, 0, 4'b1011, 4'b1000, 1, 2'd3);
    add("age_fu1", 0, 0, 4'b0011, 4'b0010, 1, 2'd1);
    add("age_fu0", 0, 0, 4'b0001, 4'b0001, 1, 2'd0);
`else
    for (int k = 0; k < 5; k++) add("idle", 0, 0, 4'b0000, 4'b0000, 0, 2'd0);
    for (int k = 0; k < 8; k++) begin
      logic [N-1:0] one = 4'b0001;
      add("rr_all", 0, 0, 4'b1111, one << (k % 4), 1, 2'(k % 4));
    end
    add("single_fu2", 0, 0, 4'b0100, 4'b0100, 1, 2'd2);
    add("single_fu3", 0, 0, 4'b1000, 4'b1000, 1, 2'd3);
    add("flush", 0, 1, 4'b0011, 4'b0000, 0, 2'd3);
    add("post_flush0", 0, 0, 4'b0011, 4'b0001, 1, 2'd0);
    add("post_flush1", 0, 0, 4'b0011, 4'b0010, 1, 2'd1);
    add("idle_hold", 0, 0, 4'b0000, 4'b0000, 0, 2'd1);
`endif
    foreach (tbl[i])
      step(tbl[i].rst, tbl[i].fl, tbl[i].v, tbl[i].nm, 1, tbl[i].er, tbl[i].ecv, tbl[i].esrc);
`ifndef CDB_AGE_PRIO_EN
    chk("conflict_after_table", 64'(conflict_cycles), 64'd11);
`endif

    // randomized: requesters hold until granted, then maybe re-arm
    begin
      logic [N-1:0] pend = '0;
      for (int c = 0; c < 600; c++) begin
        logic r, f;
        for (int i = 0; i < N; i++)
          if (!pend[i] || last_ready[i]) begin
            pend[i] = ($urandom_range(0, 99) < 60);
            tg[i]   = 3'($urandom);
            vl[i]   = $urandom;
          end
        rob_head = 3'($urandom);
        r = ($urandom_range(0, 99) < 2);
        f = ($urandom_range(0, 99) < 10);
        step(r, f, pend, "rand", 0, '0, 0, '0);
      end
    end

    // saturation: two requesters held for 300 cycles after reset
    step(1, 0, 4'b0000, "sat_rst", 0, '0, 0, '0);
    for (int c = 0; c < 300; c++) step(0, 0, 4'b0011, "sat", 0, '0, 0, '0);
    chk("conflict_saturated", 64'(conflict_cycles), 64'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_FU, default 4: number of functional-unit requesters sharing the common data bus (CDB).
REQ-002 Parameter TAG_WIDTH, default 3: ROB tag width; ROB depth is 2**TAG_WIDTH.
REQ-003 Parameter DATA_WIDTH, default 32: result value width.
REQ-004 Parameter CYCLE_WIDTH, default 8: width of the contention statistics counter.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 Port clk, input, 1: sole clock; all state updates on rising edge.
REQ-007 Port reset, input, 1: synchronous active-high reset.
REQ-008 Port req_valid, input, NUM_FU: FU i has a completed result pending.
REQ-009 Port req_tag, input, NUM_FU x TAG_WIDTH: ROB tag of FU i's result.
REQ-010 Port req_value, input, NUM_FU x DATA_WIDTH: result value of FU i.
REQ-011 Port req_ready, output, NUM_FU: combinational one-hot grant; transfer when req_valid[i] && req_ready[i].
REQ-012 Port rob_head, input, TAG_WIDTH: tag of the oldest ROB entry.
REQ-013 Port flush, input, 1: misprediction squash; suppresses grants this cycle.
REQ-014 Port cdb_valid, output, 1: registered broadcast valid.
REQ-015 Port cdb_tag, output, TAG_WIDTH: registered broadcast tag.
REQ-016 Port cdb_value, output, DATA_WIDTH: registered broadcast value.
REQ-017 Port cdb_src, output, $clog2(NUM_FU): index of the granted FU for the current broadcast.
REQ-018 Port conflict_cycles, output, CYCLE_WIDTH: count of cycles with two or more req_valid bits high.

Function
REQ-019 req_ready SHALL have at most one bit set, and only for an FU with req_valid high.
REQ-020 If any req_valid bit is high and flush is low, exactly one grant SHALL be issued that cycle.
REQ-021 The granted tag/value/index SHALL appear on cdb_tag/cdb_value/cdb_src with cdb_valid=1 on the next cycle (latency 1).
REQ-022 With no grant in a cycle, cdb_valid SHALL be 0 on the next cycle; cdb_tag/cdb_value/cdb_src hold their previous values.
REQ-023 Default policy round-robin: pointer rr_ptr names the highest-priority FU; search order is rr_ptr, rr_ptr+1, ... mod NUM_FU.
REQ-024 After a grant to FU i, rr_ptr SHALL become (i+1) mod NUM_FU; with no grant, rr_ptr is unchanged.
REQ-025 A non-granted requester SHALL keep req_valid high with stable tag/value until granted; the arbiter relies on this and does not buffer it.
REQ-026 flush high: req_ready all 0, rr_ptr unchanged, cdb_valid 0 next cycle; conflict_cycles still counts.
REQ-027 conflict_cycles SHALL saturate at all-ones and not wrap.

Reset
REQ-028 On reset: cdb_valid=0, cdb_tag=0, cdb_value=0, cdb_src=0, conflict_cycles=0, rr_ptr=0; req_ready=0 during the reset cycle.
REQ-029 Reset SHALL take priority over flush and over any pending request; an in-flight broadcast is dropped.

Configuration
REQ-030 Macro CDB_AGE_PRIO_EN defined: grant SHALL go to the requester with smallest age = (req_tag - rob_head) mod 2**TAG_WIDTH, ties to lowest index; rr_ptr is not implemented.
REQ-031 CDB_AGE_PRIO_EN undefined: round-robin per REQ-023/REQ-024; rob_head is unused.

Structure
REQ-032 NUM_FU, TAG_WIDTH, DATA_WIDTH and a cdb_bcast_t struct (valid, tag, value, src) SHALL reside in params_pkg.
REQ-033 Selection logic SHALL be a sub-module cdb_pick (round-robin or age compare), instantiated once; cdb_arbiter holds the registers.

Verification
REQ-034 Reset, then req_valid=4'b0000 for 5 cycles -> cdb_valid=0, req_ready=0, conflict_cycles=0 throughout.
REQ-035 Round-robin, req_valid=4'b1111 held 8 cycles -> grants FU0,1,2,3,0,1,2,3; cdb_src follows one cycle later; conflict_cycles=8.
REQ-036 Single request FU2 tag=5 value=0xDEADBEEF -> req_ready=4'b0100 same cycle; next cycle cdb_valid=1, cdb_tag=5, cdb_value=0xDEADBEEF, cdb_src=2.
REQ-037 flush=1 with req_valid=4'b0011 -> req_ready=0, next cdb_valid=0, rr_ptr unchanged; flush=0 next cycle -> FU rr_ptr granted.
REQ-038 CDB_AGE_PRIO_EN, rob_head=6, FU0 tag=1, FU1 tag=7, FU3 tag=6 -> FU3 (age 0), then FU1 (age 1), then FU0 (age 3).
REQ-039 Hold req_valid=4'b0011 for 300 cycles (grants retire one per cycle, requesters re-assert) -> conflict_cycles saturates at 255.
